// File: rtl/ifetch_unit_pkg.sv
// ============================================================================
// Module : ifetch_unit_pkg
// Brief  : Shared encodings for the miniRV instruction fetch unit
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ifetch_unit_pkg;

    typedef enum logic [1:0] {
        NPC_PC4   = 2'd0,
        NPC_PCIMM = 2'd1,
        NPC_IMM   = 2'd2
    } npc_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Control-flow target, word aligned; the add wraps naturally at 32 bits.
    function automatic logic [31:0] redirect_target(
        input logic [1:0]  op,
        input logic [31:0] pc,
        input logic [31:0] imm,
        input logic [31:0] aluc
    );
        logic [31:0] t;
        t = (op == NPC_IMM) ? aluc : (pc + imm);
        return {t[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifetch_unit_buf.sv
// ============================================================================
// Module : ifetch_buf
// Brief  : Small {pc, inst} FIFO with flush; head is driven from flops only
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ifetch_buf
    import ifetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [31:0]   push_pc,
    input  logic [31:0]   push_inst,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic          head_valid,
    output logic [31:0]   head_pc,
    output logic [31:0]   head_inst
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign head_valid = (count != '0);
    assign do_pop     = pop && head_valid;
    assign do_push    = push && ((count != CW'(DEPTH)) || do_pop);

    // Empty buffer presents a NOP at PC 0 so stale or flushed words never leak.
    assign head_pc    = head_valid ? pc_mem[rd_ptr]   : 32'h0000_0000;
    assign head_inst  = head_valid ? inst_mem[rd_ptr] : NOP_INST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            pc_mem[wr_ptr]   <= push_pc;
            inst_mem[wr_ptr] <= push_inst;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ifetch_unit.sv
// ============================================================================
// Module : ifetch_unit
// Brief  : PC owner and imem req/gnt/rvalid fetcher with redirect flushing
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_inst,
    output logic [31:0] IF_pc,
    output logic        IF_valid,
    input  logic        ID_ready,
    input  logic        redirect_valid,
    input  logic [1:0]  npc_op,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] redirect_imm,
    input  logic [31:0] redirect_aluc
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    fetch_state_e  state;
    fetch_state_e  state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_nxt;
    logic [31:0]   req_pc;
    logic [31:0]   req_pc_nxt;
    logic [CW-1:0] buf_count;
    logic [31:0]   occupancy;
    logic [31:0]   target;
    logic          outstanding;
    logic          pop;
    logic          issue_ok;
    logic          redirect;
    logic          granted;
    logic          push;

    // WAIT and DROP are exactly the states with one request in flight.
    assign outstanding = (state == S_WAIT) || (state == S_DROP);
    assign pop         = IF_valid & ID_ready;
    assign occupancy   = 32'(buf_count) + 32'(outstanding) - 32'(pop);
    assign issue_ok    = occupancy < 32'(BUF_DEPTH);

    assign redirect = redirect_valid && ((npc_op == NPC_PCIMM) || (npc_op == NPC_IMM));
    assign target   = redirect_target(npc_op, redirect_pc, redirect_imm, redirect_aluc);

    assign imem_req  = (state == S_REQ) || ((state == S_WAIT) && imem_rvalid && issue_ok);
    assign imem_addr = fetch_pc;
    assign granted   = imem_req && imem_gnt;
    assign push      = (state == S_WAIT) && imem_rvalid && !redirect;

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        req_pc_nxt   = req_pc;

        case (state)
            S_IDLE: if (issue_ok) state_nxt = S_REQ;
            S_REQ:  if (imem_gnt) state_nxt = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (!issue_ok)     state_nxt = S_IDLE;
                    else if (imem_gnt) state_nxt = S_WAIT;
                    else               state_nxt = S_REQ;
                end
            end
            S_DROP: if (imem_rvalid) state_nxt = issue_ok ? S_REQ : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        if (granted) begin
            fetch_pc_nxt = fetch_pc + 32'd4;
            req_pc_nxt   = fetch_pc;
        end

        // Any response still owed after this cycle belongs to the old path.
        if (redirect) begin
            fetch_pc_nxt = target;
            state_nxt    = ((outstanding && !imem_rvalid) || granted) ? S_DROP : S_REQ;
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            req_pc   <= req_pc_nxt;
        end
    end

    ifetch_buf #(
        .DEPTH (BUF_DEPTH),
        .CW    (CW)
    ) u_buf (
        .clk        (cpu_clk),
        .rst        (cpu_rst),
        .flush      (redirect),
        .push       (push),
        .push_pc    (req_pc),
        .push_inst  (imem_rdata),
        .pop        (pop),
        .count      (buf_count),
        .head_valid (IF_valid),
        .head_pc    (IF_pc),
        .head_inst  (IF_inst)
    );

endmodule

`default_nettype wire

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch unit for the single-cycle/pipelined miniRV core: owns the PC, issues requests to instruction memory over a req/gnt/rvalid handshake, buffers returned instructions with their PCs, and presents them to the control/decode stage. It also accepts the redirect that control produces (npc_op with branch/jump targets) and flushes wrong-path fetches.

## Interface
- RESET_PC, 32'h0000_0000, PC of first fetch after reset
- BUF_DEPTH, 2, instruction buffer entries (power of two, ≥2)
- cpu_clk  in  1  clock, all state on rising edge
- cpu_rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request
- imem_addr  out  32  byte address, bits[1:0] always 0
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid, in order, at least 1 cycle after gnt
- imem_rdata  in  32  instruction word
- IF_inst  out  32  instruction to decode
- IF_pc  out  32  PC of IF_inst
- IF_valid  out  1  IF_inst/IF_pc valid
- ID_ready  in  1  decode consumes entry when IF_valid & ID_ready
- redirect_valid  in  1  qualifies npc_op this cycle
- npc_op  in  2  pc4 / pcImm / Imm (param.v encodings)
- redirect_pc  in  32  base PC for pcImm
- redirect_imm  in  32  sign-extended offset for pcImm
- redirect_aluc  in  32  jalr target for Imm

## Operation
- FSM: IDLE, REQ, WAIT, DROP.
- IDLE: no request in flight; go REQ when issue allowed.
- REQ: imem_req=1, imem_addr=fetch_pc. On gnt: fetch_pc+=4, outstanding=1, go WAIT.
- WAIT: on rvalid push {fetch_pc_of_request, imem_rdata} into buffer; same cycle may assert imem_req for next PC if issue allowed (back-to-back); else IDLE.
- DROP: one granted response belongs to a flushed path; on rvalid discard it, go REQ (or IDLE if not allowed).
- Issue allowed when count + outstanding − pop < BUF_DEPTH, pop = IF_valid & ID_ready.
- At most one request outstanding.
- Redirect (redirect_valid & npc_op≠pc4): target = redirect_pc+redirect_imm (pcImm) or redirect_aluc (Imm), bits[1:0] forced 0, wrap mod 2^32. Next cycle: buffer empty, fetch_pc=target.
  - Outstanding or granted this cycle, response not yet received → DROP.
  - rvalid in redirect cycle → response discarded, not pushed.
  - In REQ without gnt → address switches to target next cycle; imem tolerates address change before gnt.
  - Pop in redirect cycle still counts as consumed.
- npc_op=pc4 with redirect_valid: no effect.
- Buffer full: imem_req held 0; no response can arrive (credit rule).
- Buffer empty with rvalid and ID_ready: entry appears on IF_* next cycle (no bypass).

## Timing
- Reset (async, any state): state IDLE, fetch_pc=RESET_PC, buffer empty, outstanding=0, imem_req=0, imem_addr=RESET_PC, IF_valid=0, IF_inst=32'h0000_0013, IF_pc=0. In-flight response arriving after reset released is ignored only if its rvalid occurs during reset; memory is reset together with the core.
- First cycle after reset release: IDLE→REQ; imem_req rises in cycle 1.
- Zero-wait memory (gnt same cycle, rvalid next): first IF_valid at cycle 3 after release; sustained 1 instruction/cycle while ID_ready=1.
- Redirect in cycle N: first request to target in N+1 (or after DROP response); no wrong-path IF_valid in N+1 onward.
- IF_* registered, stable while IF_valid & !ID_ready.

## Structure
- param.v: npc_op encodings (pc4, pcImm, Imm), NOP constant 32'h0000_0013, FSM state encodings.
- Sub-module ifetch_buf: BUF_DEPTH FIFO of {pc, inst}, push/pop/flush, count output, registered head.

## Test plan
- Reset release, zero-wait memory returning addr as data, ID_ready=1 → IF_pc 0,4,8,… on consecutive cycles from cycle 3, IF_inst matching.
- ID_ready=0 for 5 cycles → buffer fills to 2, imem_req deasserts, IF_pc held at 0; ready again → 4,8 follow without gap or duplicate.
- pcImm redirect, redirect_pc=0x10, imm=0xFFFF_FFF8, with response outstanding → response dropped, next imem_addr=0x08, next IF_pc=0x08.
- Imm redirect redirect_aluc=0x0000_0103 → imem_addr=0x100; redirect coincident with rvalid → that word never appears on IF_*.
- Memory with 3-cycle rvalid latency and gnt stalls → one outstanding max, addresses strictly +4, no lost/duplicated instructions.
- cpu_rst asserted mid-WAIT → outputs at reset values same cycle (async), refetch from RESET_PC after release.
